psum_wb_ctrl: RTL and testbench

PSUM_WB_CTRL -- requirements
Module: psum_wb_ctrl

---
 rtl/psum_wb_ctrl_pkg.sv | 15 +
 rtl/psum_wb_ctrl_if.sv | 32 +++
 rtl/psum_wb_ctrl.sv | 92 +++++++++
 tb/tb_psum_wb_ctrl.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/psum_wb_ctrl_pkg.sv
// rtl/psum_wb_ctrl_pkg.sv - shared state encoding and width defaults for the psum write-back controller
package psum_wb_ctrl_pkg;

    localparam int PSUM_BW_DEF = 16;
    localparam int COL_DEF     = 8;
    localparam int ADDR_BW_DEF = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } wb_state_e;

endpackage

// File: rtl/psum_wb_ctrl_if.sv
// rtl/psum_wb_ctrl_if.sv - job control, OFIFO and psum memory signals of the write-back controller
interface psum_wb_ctrl_if
    import psum_wb_ctrl_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int col     = COL_DEF,
    parameter int addr_bw = ADDR_BW_DEF
);
    logic                     start;
    logic [addr_bw-1:0]       base_addr;
    logic [addr_bw-1:0]       count;
    logic                     abort;
    logic                     ofifo_valid;
    logic [psum_bw*col-1:0]   ofifo_rdata;
    logic                     ofifo_rd;
    logic                     mem_cen;
    logic                     mem_wen;
    logic [addr_bw-1:0]       mem_addr;
    logic [psum_bw*col-1:0]   mem_d;
    logic                     busy;
    logic                     done;

    modport master (
        output start, base_addr, count, abort, ofifo_valid, ofifo_rdata,
        input  ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d, busy, done
    );

    modport slave (
        input  start, base_addr, count, abort, ofifo_valid, ofifo_rdata,
        output ofifo_rd, mem_cen, mem_wen, mem_addr, mem_d, busy, done
    );
endinterface

// File: rtl/psum_wb_ctrl.sv
// rtl/psum_wb_ctrl.sv - drains OFIFO words into consecutive psum memory addresses
module psum_wb_ctrl
    import psum_wb_ctrl_pkg::*;
#(
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int col     = COL_DEF,
    parameter int addr_bw = ADDR_BW_DEF
) (
    input logic           clk,
    input logic           reset,
    psum_wb_ctrl_if.slave bus
);
    wb_state_e              state_q, state_d;
    logic [addr_bw-1:0]     remaining_q, remaining_d;
    logic [addr_bw-1:0]     wptr_q, wptr_d;
    logic [addr_bw-1:0]     mem_addr_q, mem_addr_d;
    logic [psum_bw*col-1:0] mem_d_q, mem_d_d;
    logic                   wr_q, wr_d;
    logic                   pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            wptr_q      <= '0;
            mem_addr_q  <= '0;
            mem_d_q     <= '0;
            wr_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            wptr_q      <= wptr_d;
            mem_addr_q  <= mem_addr_d;
            mem_d_q     <= mem_d_d;
            wr_q        <= wr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        wptr_d      = wptr_q;
        mem_addr_d  = mem_addr_q;
        mem_d_d     = mem_d_q;
        wr_d        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.count != '0) begin
                        state_d     = ST_DRAIN;
                        remaining_d = bus.count;
                        wptr_d      = bus.base_addr;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DRAIN: begin
                // abort only blocks new pops; a write registered last cycle is already on the bus
                pop = bus.ofifo_valid && (remaining_q != '0) && !bus.abort;
                if (bus.abort) begin
                    state_d = ST_DONE;
                end else if (pop) begin
                    remaining_d = remaining_q - addr_bw'(1);
                    if (remaining_q == addr_bw'(1)) begin
                        state_d = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (pop) begin
            mem_d_d    = bus.ofifo_rdata;
            mem_addr_d = wptr_q;
            wptr_d     = wptr_q + addr_bw'(1);
            wr_d       = 1'b1;
        end
    end

    assign bus.ofifo_rd = pop;
    assign bus.mem_cen  = ~wr_q;
    assign bus.mem_wen  = ~wr_q;
    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_d    = mem_d_q;
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
endmodule

// File: tb/tb_psum_wb_ctrl.sv
// tb/tb_psum_wb_ctrl.sv - directed self-checking bench for psum_wb_ctrl
module tb_psum_wb_ctrl;
    localparam int PB  = 16;
    localparam int COL = 8;
    localparam int AB  = 11;
    localparam int DW  = PB * COL;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;
    int   fifo_idx = 0;
    int   seed = 0;
    string cur = "reset";

    psum_wb_ctrl_if #(.psum_bw(PB), .col(COL), .addr_bw(AB)) bus ();

    psum_wb_ctrl #(.psum_bw(PB), .col(COL), .addr_bw(AB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mk_word(input int n);
        logic [DW-1:0] w;
        for (int c = 0; c < COL; c++) begin
            w[c*PB +: PB] = PB'(n * 256 + c * 17 + 1);
        end
        return w;
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s/%s: got %h expected %h", cur, tag, got, exp);
        end
    endtask

    task automatic launch(input logic [AB-1:0] base, input logic [AB-1:0] cnt);
        @(negedge clk);
        bus.start = 1'b1;
        bus.base_addr = base;
        bus.count = cnt;
        bus.ofifo_valid = 1'b0;
        bus.abort = 1'b0;
        fifo_idx = 0;
        #1;
        chk("idle_busy", DW'(bus.busy), DW'(1'b0));
        chk("idle_rd", DW'(bus.ofifo_rd), DW'(1'b0));
    endtask

    // widx < 0 skips the address/data comparison for that cycle
    task automatic cyc(input logic s, input logic v, input logic a, input logic e_rd, input logic e_wr,
                       input logic [AB-1:0] e_addr, input int e_widx, input logic e_done, input logic e_busy);
        @(negedge clk);
        bus.start = s;
        bus.ofifo_valid = v;
        bus.abort = a;
        bus.ofifo_rdata = mk_word(seed + fifo_idx);
        #1;
        chk("rd", DW'(bus.ofifo_rd), DW'(e_rd));
        chk("cen", DW'(bus.mem_cen), DW'(!e_wr));
        chk("wen", DW'(bus.mem_wen), DW'(!e_wr));
        if (e_widx >= 0) begin
            chk("addr", DW'(bus.mem_addr), DW'(e_addr));
            chk("data", bus.mem_d, mk_word(seed + e_widx));
        end
        chk("done", DW'(bus.done), DW'(e_done));
        chk("busy", DW'(bus.busy), DW'(e_busy));
        if (bus.ofifo_rd) fifo_idx++;
    endtask

    initial begin
        bus.start = 1'b0;
        bus.base_addr = '0;
        bus.count = '0;
        bus.abort = 1'b0;
        bus.ofifo_valid = 1'b0;
        bus.ofifo_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rd", DW'(bus.ofifo_rd), DW'(1'b0));
        chk("cen", DW'(bus.mem_cen), DW'(1'b1));
        chk("wen", DW'(bus.mem_wen), DW'(1'b1));
        chk("addr", DW'(bus.mem_addr), DW'(0));
        chk("data", bus.mem_d, '0);
        chk("busy", DW'(bus.busy), DW'(1'b0));
        chk("done", DW'(bus.done), DW'(1'b0));
        @(negedge clk);
        reset = 1'b0;

        cur = "burst"; seed = 16'h10;
        launch(11'h010, 11'd4);
        cyc(0, 1, 0, 1, 0, 11'h000, -1, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h010, 0, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h011, 1, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h012, 2, 0, 1);
        cyc(0, 1, 0, 0, 1, 11'h013, 3, 0, 1);
        cyc(0, 0, 0, 0, 0, 11'h013, 3, 1, 1);
        cyc(0, 0, 0, 0, 0, 11'h013, 3, 0, 0);

        cur = "stall"; seed = 16'h20;
        launch(11'h100, 11'd3);
        cyc(0, 1, 0, 1, 0, 11'h000, -1, 0, 1);
        cyc(0, 0, 0, 0, 1, 11'h100, 0, 0, 1);
        cyc(1, 0, 0, 0, 0, 11'h100, 0, 0, 1);
        cyc(0, 1, 0, 1, 0, 11'h100, 0, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h101, 1, 0, 1);
        cyc(0, 0, 0, 0, 1, 11'h102, 2, 0, 1);
        cyc(0, 0, 0, 0, 0, 11'h102, 2, 1, 1);
        cyc(0, 0, 0, 0, 0, 11'h102, 2, 0, 0);

        cur = "wrap"; seed = 16'h30;
        launch(11'h7FE, 11'd4);
        cyc(0, 1, 0, 1, 0, 11'h000, -1, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h7FE, 0, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h7FF, 1, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h000, 2, 0, 1);
        cyc(0, 0, 0, 0, 1, 11'h001, 3, 0, 1);
        cyc(0, 0, 0, 0, 0, 11'h001, 3, 1, 1);
        cyc(0, 0, 0, 0, 0, 11'h001, 3, 0, 0);

        cur = "zero";
        launch(11'h055, 11'd0);
        cyc(0, 1, 0, 0, 0, 11'h001, 3, 1, 1);
        cyc(0, 1, 0, 0, 0, 11'h001, 3, 0, 0);

        cur = "abort"; seed = 16'h40;
        launch(11'h200, 11'd8);
        cyc(0, 1, 0, 1, 0, 11'h000, -1, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h200, 0, 0, 1);
        cyc(0, 1, 0, 1, 1, 11'h201, 1, 0, 1);
        cyc(0, 1, 1, 0, 1, 11'h202, 2, 0, 1);
        cyc(0, 1, 0, 0, 0, 11'h202, 2, 1, 1);
        cyc(0, 1, 0, 0, 0, 11'h202, 2, 0, 0);
        cur = "restart"; seed = 16'h50;
        launch(11'h300, 11'd1);
        cyc(0, 1, 0, 1, 0, 11'h000, -1, 0, 1);
        cyc(0, 1, 0, 0, 1, 11'h300, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 11'h300, 0, 1, 1);
        cyc(0, 0, 0, 0, 0, 11'h300, 0, 0, 0);

        cur = "reset_mid"; seed = 16'h60;
        launch(11'h040, 11'd4);
        cyc(0, 1, 0, 1, 0, 11'h000, -1, 0, 1);
        @(negedge clk);
        bus.ofifo_rdata = mk_word(seed + fifo_idx);
        #1;
        chk("rd_before", DW'(bus.ofifo_rd), DW'(1'b1));
        chk("cen_before", DW'(bus.mem_cen), DW'(1'b0));
        reset = 1'b1;
        #1;
        chk("rst_rd", DW'(bus.ofifo_rd), DW'(1'b0));
        chk("rst_cen", DW'(bus.mem_cen), DW'(1'b1));
        chk("rst_wen", DW'(bus.mem_wen), DW'(1'b1));
        chk("rst_addr", DW'(bus.mem_addr), DW'(0));
        chk("rst_data", bus.mem_d, '0);
        chk("rst_busy", DW'(bus.busy), DW'(1'b0));
        chk("rst_done", DW'(bus.done), DW'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        cyc(0, 1, 0, 0, 0, 11'h000, -1, 0, 0);
        cyc(0, 1, 0, 0, 0, 11'h000, -1, 0, 0);
        chk("post_addr", DW'(bus.mem_addr), DW'(0));
        chk("post_data", bus.mem_d, '0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
